// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types, defaults and mask helpers for the pattern detector
package seq_detect_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 4;
  localparam bit LEN_ZERO_IS_MAX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // A 3-bit length field cannot express 8 directly, so 0 stands in for it.
  function automatic logic [3:0] eff_len(input logic [2:0] len);
    if (len == 3'd0) begin
      eff_len = LEN_ZERO_IS_MAX ? 4'd8 : 4'd0;
    end else begin
      eff_len = {1'b0, len};
    end
  endfunction

  function automatic logic [DEF_PAT_W-1:0] len_to_mask(input logic [2:0] len);
    logic [DEF_PAT_W-1:0] m;
    logic [3:0]           n;
    n = eff_len(len);
    for (int i = 0; i < DEF_PAT_W; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// rtl/seq_shift_cmp.sv - serial window, bits-seen counter and masked pattern compare
module seq_shift_cmp
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [2:0]       len,
  output logic             hit
);

  logic [PAT_W-1:0]     window_q, window_d;
  logic [3:0]           seen_q, seen_d;
  logic [DEF_PAT_W-1:0] mask_full;
  logic [PAT_W-1:0]     mask;

  always_comb begin
    window_d = window_q;
    seen_d   = seen_q;
    if (clear) begin
      window_d = '0;
      seen_d   = 4'd0;
    end else if (shift_en) begin
      window_d = {window_q[PAT_W-2:0], bit_in};
      seen_d   = (seen_q == 4'd8) ? seen_q : seen_q + 4'd1;
    end
  end

  // Compare against the post-shift window so the hit lines up with the completing bit.
  always_comb begin
    mask_full = len_to_mask(len);
    mask      = mask_full[PAT_W-1:0];
    hit       = shift_en && !clear && (seen_d >= eff_len(len)) &&
                ((window_d & mask) == (pattern & mask));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      window_q <= '0;
      seen_q   <= 4'd0;
    end else begin
      window_q <= window_d;
      seen_q   <= seen_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run controller: load/run/done sequencing, hit counting and budget
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_hits,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] hit_count,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_q, match_d;
  logic             clear, shift_en, hit;

  assign clear    = (state_q == ST_LOAD);
  assign shift_en = (state_q == ST_RUN) && bit_valid;
  assign cnt_inc  = (hit_count_q == CNT_MAX) ? hit_count_q : hit_count_q + 1'b1;

  seq_shift_cmp #(.PAT_W(PAT_W)) u_shift_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    hits_d      = hits_q;
    hit_count_d = hit_count_q;
    match_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pat_d       = cfg_pattern;
        len_d       = cfg_len;
        hits_d      = cfg_hits;
        hit_count_d = '0;
        state_d     = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // An abort swallows any hit landing in the same cycle.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          match_d     = 1'b1;
          hit_count_d = cnt_inc;
          if (hits_q != '0 && cnt_inc == hits_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= 3'd0;
      hits_q      <= '0;
      hit_count_q <= '0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      hits_q      <= hits_d;
      hit_count_q <= hit_count_d;
      match_q     <= match_d;
    end
  end

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign match     = match_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - table and sequence driven scoreboard bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  localparam int PW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [2:0]    cfg_len = 3'd0;
  logic [CW-1:0] cfg_hits = '0;
  logic          busy, match, done;
  logic [CW-1:0] hit_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, st, sp, bv, bi;
    logic       em, eb, ed;
    logic [3:0] eh;
  } vec_t;

  typedef struct {
    logic       em, eb, ed;
    logic [3:0] eh;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];

  seq_detect_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_hits    (cfg_hits),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .match       (match),
    .hit_count   (hit_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, st, sp, bv, bi, em, eb, ed,
                              input logic [3:0] eh);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.bv = bv; v.bi = bi;
    v.em = em; v.eb = eb; v.ed = ed; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n     = v.rst;
    start     = v.st;
    stop      = v.sp;
    bit_valid = v.bv;
    bit_in    = v.bi;
    e.em = v.em; e.eb = v.eb; e.ed = v.ed; e.eh = v.eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " match"},     {3'b0, match}, {3'b0, e.em});
    chk({tag, " busy"},      {3'b0, busy},  {3'b0, e.eb});
    chk({tag, " done"},      {3'b0, done},  {3'b0, e.ed});
    chk({tag, " hit_count"}, hit_count,     e.eh);
  endtask

  task automatic set_cfg(input logic [PW-1:0] p, input logic [2:0] l, input logic [CW-1:0] h);
    @(negedge clk);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_hits    = h;
  endtask

  initial begin
    logic [PW-1:0] pat;
    logic [3:0]    eh;

    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "reset0");
    step(mk(1, 1, 0, 1, 1, 0, 0, 0, 0), "reset1");

    // basic run: pattern 101, budget 2, overlapping hits
    set_cfg(8'b0000_0101, 3'd3, 4'd2);
    tbl[0] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[4] = mk(0, 0, 0, 1, 1, 1, 1, 0, 1);
    tbl[5] = mk(0, 0, 0, 1, 0, 0, 1, 0, 1);
    tbl[6] = mk(0, 0, 0, 1, 1, 1, 0, 1, 2);
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2);
    tbl[8] = mk(0, 1, 1, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("basic[%0d]", i));

    // length 0 means 8: A5 then seven trailing zeros
    pat = 8'hA5;
    set_cfg(pat, 3'd0, 4'd0);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 2), "len0 start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "len0 load");
    for (int i = 7; i >= 0; i--)
      step(mk(0, 0, 0, 1, pat[i], (i == 0), 1, 0, (i == 0) ? 4'd1 : 4'd0),
           $sformatf("len0 bit%0d", i));
    for (int i = 0; i < 7; i++) step(mk(0, 0, 0, 1, 0, 0, 1, 0, 1), $sformatf("len0 tail%0d", i));
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1), "len0 stop");

    // all-zero pattern: a cleared window aliases it, so only bits_seen gates the hit
    set_cfg(8'h00, 3'd0, 4'd0);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 1), "alias start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "alias load");
    for (int i = 0; i < 9; i++) begin
      eh = (i < 7) ? 4'd0 : 4'(i - 6);
      step(mk(0, 0, 0, 1, 0, (i >= 7), 1, 0, eh), $sformatf("alias bit%0d", i));
    end
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 2), "alias stop");

    // budget 0: twenty ones with a 1-bit pattern, count saturates at 15
    set_cfg(8'h01, 3'd1, 4'd0);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 2), "b0 start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "b0 load");
    for (int i = 0; i < 20; i++) begin
      eh = (i >= 14) ? 4'd15 : 4'(i + 1);
      step(mk(0, 0, 0, 1, 1, 1, 1, 0, eh), $sformatf("b0 one%0d", i));
    end
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 15), "b0 stop");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 15), "b0 idle");

    // abort collision: stop on the completing bit discards the hit
    set_cfg(8'b0000_0101, 3'd3, 4'd0);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 15), "abort start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "abort load");
    step(mk(0, 0, 0, 1, 1, 0, 1, 0, 0), "abort b1");
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0), "abort b2");
    step(mk(0, 0, 0, 1, 1, 1, 1, 0, 1), "abort b3");
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 1), "abort b4");
    step(mk(0, 0, 1, 1, 1, 0, 0, 0, 1), "abort collide");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "abort idle");
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 1), "abort start+stop");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "abort still idle");

    // gaps and config isolation: latched 110, inputs changed after LOAD
    set_cfg(8'b0000_0110, 3'd3, 4'd1);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 1), "gap start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "gap load");
    cfg_pattern = 8'b0000_0101;
    cfg_len     = 3'd2;
    cfg_hits    = 4'd0;
    step(mk(0, 0, 0, 1, 1, 0, 1, 0, 0), "gap b1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "gap hole1");
    step(mk(0, 0, 0, 1, 1, 0, 1, 0, 0), "gap b2");
    step(mk(0, 0, 0, 0, 1, 0, 1, 0, 0), "gap hole2");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "gap hole3");
    step(mk(0, 0, 0, 1, 0, 1, 0, 1, 1), "gap b3");
    step(mk(0, 0, 0, 1, 0, 0, 0, 1, 1), "gap done hold");
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1), "gap stop");

    // reset mid-run with hit_count=1
    set_cfg(8'b0000_0101, 3'd3, 4'd0);
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 1), "rst start");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "rst load");
    step(mk(0, 0, 0, 1, 1, 0, 1, 0, 0), "rst b1");
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0), "rst b2");
    step(mk(0, 0, 0, 1, 1, 1, 1, 0, 1), "rst b3");
    step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0), "rst assert");
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0), "rst idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for the team's serial Mealy pattern detector.
- Accepts a programmable pattern (1..8 bits) and a hit budget.
- Sequences the detector through load/run/done phases.
- Counts overlapping matches and raises done when the budget is met.
- Sits between ui_in-driven control/serial inputs and uo_out status bits in the top-level wrapper.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 4, width of hit budget and hit counter

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous reset, active-high (rst_n=1 resets on the clk edge)
start  input  1  pulse: latch config and begin a run (honoured in IDLE/DONE only)
stop  input  1  pulse: abort run, return to IDLE
cfg_pattern  input  PAT_W  pattern; bit[len-1] is the first bit received, bit[0] the last
cfg_len  input  3  pattern length; 0 encodes 8
cfg_hits  input  CNT_W  hit budget; 0 means run until stop (no done)
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in qualifier; one bit consumed per valid cycle
busy  output  1  high in LOAD and RUN
match  output  1  one-cycle pulse per detected pattern
hit_count  output  CNT_W  matches in current run, saturating
done  output  1  high in DONE, held until start or stop

Behaviour:
- Reset: state=IDLE. busy=0, match=0, hit_count=0, done=0. Shift window and latched config are cleared to 0.
- States: IDLE, LOAD, RUN, DONE. They are encoded 2'b00..2'b11 in that order.
- IDLE: on start, go to LOAD. bit_valid is ignored.
- LOAD (1 cycle):
  - Latch cfg_pattern, cfg_len and cfg_hits into shadow registers.
  - Clear the window and hit_count.
  - Go to RUN.
  - Config inputs are don't-care after LOAD.
- RUN: on each bit_valid cycle, window <= {window[PAT_W-2:0], bit_in}.
  - A candidate hit is computed combinationally from the next window value: (next_window & mask) == (pattern & mask).
  - mask has its low len bits set.
  - A hit is only allowed once at least len valid bits have been shifted since LOAD. A bits_seen counter, saturating at 8, tracks this.
  - match is registered: it asserts on the cycle after the valid bit that completes the pattern.
  - Detection is overlapping: the window is not cleared after a hit.
  - On a hit, hit_count increments and saturates at 2^CNT_W-1.
  - If cfg_hits!=0 and the increment makes hit_count==cfg_hits, go to DONE. done and the final match rise together on the next cycle.
- DONE:
  - busy=0, done=1. hit_count holds its value.
  - start goes to LOAD and clears done in that cycle.
  - stop goes to IDLE.
- stop in LOAD or RUN: go to IDLE next cycle.
  - hit_count holds its last value until the next LOAD.
  - A hit coincident with stop is discarded: no match pulse, no increment.
- start with stop in the same cycle: stop wins.
- start during LOAD or RUN: ignored.
- bit_valid=0 cycles: the window, bits_seen and the match path do not change.
- rst_n during any state: synchronous return to reset values on that edge. It overrides start and stop.
- Latency: valid bit completing the pattern to match/hit_count update is 1 clk. start to busy is 1 clk.

Decomposition:
- Package seq_detect_pkg holds:
  - the state enum;
  - PAT_W and CNT_W defaults;
  - the LEN_ZERO_IS_MAX constant;
  - a mask-from-length function.
- One sub-module, seq_shift_cmp, holds:
  - the window shift register;
  - the bits_seen counter;
  - the masked compare.
  - It outputs the combinational hit signal.
- seq_detect_ctrl owns the FSM, the shadow config, hit_count, match and done.

Test Plan:
- Basic run: rst_n=1 for 2 clk. cfg_pattern=8'b0000_0101, cfg_len=3, cfg_hits=2. Pulse start. Send bits 1,0,1,0,1 (each valid).
  -> match pulses after the 3rd and 5th bits (overlap); hit_count=1 then 2; done=1 and busy=0 after the 5th bit.
- Length-0 encoding: cfg_len=0, pattern=8'hA5. Send A5 MSB-first, then 7 bits of 0.
  -> exactly one match, one clk after the 8th bit; no match during the first 7 bits even if the window aliases.
- Budget 0: cfg_hits=0, pattern=1'b1, cfg_len=1. Send 20 ones with CNT_W=4.
  -> 20 match pulses; hit_count saturates at 15; done stays 0; stop then gives IDLE with hit_count=15.
- Abort collision: during RUN, assert stop on the same cycle as the valid bit completing the pattern.
  -> no match pulse; hit_count is unchanged; IDLE next cycle. start+stop together in IDLE leaves the state at IDLE.
- Gaps and config isolation: insert bit_valid=0 gaps between pattern bits, and change cfg_pattern mid-RUN.
  -> detection uses the latched pattern; the match timing follows only the valid bits.
- Reset mid-run: assert rst_n in RUN with hit_count=1.
  -> next cycle: IDLE, hit_count=0, busy=0, match=0, done=0.
